// File: rtl/omsp_lpm_sequencer.sv
// Low-power-mode sequencer: powers CPU, SMCLK and LFXT down in order and
// back up in reverse order, waiting for the oscillator to restart on wake-up.
module omsp_lpm_sequencer #(
    parameter int unsigned OSC_TICKS    = 4,
    parameter int unsigned WAKE_TIMEOUT = 1024
) (
    input  logic       mclk,
    input  logic       por_reset_a,
    input  logic       lpm_req,
    input  logic [1:0] lpm_mode,
    input  logic       wakeup,
    input  logic       dbg_en_s,
    input  logic       osc_tick,
    input  logic       fault_clr,
    output logic       cpu_en,
    output logic       scg1,
    output logic       oscoff,
    output logic       lpm_ack,
    output logic       lpm_rej,
    output logic       wake_done,
    output logic       osc_fault,
    output logic [2:0] state
);

    localparam int unsigned TICK_W = 4;
    localparam int unsigned CYC_W  = 16;
    localparam logic [TICK_W-1:0] TICK_TARGET = TICK_W'(OSC_TICKS);
    localparam logic [CYC_W-1:0]  CYC_LAST    = CYC_W'(WAKE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ACTIVE     = 3'd0,
        OFF_CPU    = 3'd1,
        OFF_SMCLK  = 3'd2,
        OFF_OSC    = 3'd3,
        SLEEP      = 3'd4,
        WAKE_OSC   = 3'd5,
        WAKE_SMCLK = 3'd6,
        WAKE_CPU   = 3'd7
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic                cpu_en_q, cpu_en_d;
    logic                scg1_q, scg1_d;
    logic                oscoff_q, oscoff_d;
    logic                ack_q, ack_d;
    logic                rej_q, rej_d;
    logic                done_q, done_d;
    logic                fault_q, fault_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [CYC_W-1:0]    cyc_cnt_q, cyc_cnt_d;
    logic [TICK_W-1:0]   tick_sat;

    // Tick count including the current pulse, saturating at all-ones
    assign tick_sat = (tick_cnt_q == '1) ? tick_cnt_q : tick_cnt_q + TICK_W'(osc_tick);

    always_ff @(posedge mclk or posedge por_reset_a) begin
        if (por_reset_a) begin
            state_q    <= ACTIVE;
            mode_q     <= '0;
            cpu_en_q   <= 1'b1;
            scg1_q     <= 1'b0;
            oscoff_q   <= 1'b0;
            ack_q      <= 1'b0;
            rej_q      <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            tick_cnt_q <= '0;
            cyc_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cpu_en_q   <= cpu_en_d;
            scg1_q     <= scg1_d;
            oscoff_q   <= oscoff_d;
            ack_q      <= ack_d;
            rej_q      <= rej_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
            tick_cnt_q <= tick_cnt_d;
            cyc_cnt_q  <= cyc_cnt_d;
        end
    end

    // Wake-up restores whichever resource was switched off last
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cpu_en_d   = cpu_en_q;
        scg1_d     = scg1_q;
        oscoff_d   = oscoff_q;
        ack_d      = 1'b0;
        rej_d      = 1'b0;
        done_d     = 1'b0;
        fault_d    = fault_clr ? 1'b0 : fault_q;
        tick_cnt_d = '0;
        cyc_cnt_d  = '0;

        if (wakeup && (state_q inside {OFF_CPU, OFF_SMCLK, OFF_OSC, SLEEP})) begin
            if (oscoff_q) begin
                state_d  = WAKE_OSC;
                oscoff_d = 1'b0;
            end else if (scg1_q) begin
                state_d = WAKE_SMCLK;
                scg1_d  = 1'b0;
            end else begin
                state_d  = WAKE_CPU;
                cpu_en_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                ACTIVE: begin
                    if (lpm_req) begin
                        if (wakeup) begin
                            rej_d = 1'b1;
                        end else begin
                            mode_d   = lpm_mode;
                            state_d  = OFF_CPU;
                            cpu_en_d = 1'b0;
                        end
                    end
                end
                OFF_CPU: begin
                    if (mode_q == 2'd0) begin
                        state_d = SLEEP;
                        ack_d   = 1'b1;
                    end else begin
                        state_d = OFF_SMCLK;
                        scg1_d  = 1'b1;
                    end
                end
                OFF_SMCLK: begin
                    if (mode_q[1] && !dbg_en_s) begin
                        state_d  = OFF_OSC;
                        oscoff_d = 1'b1;
                    end else begin
                        state_d = SLEEP;
                        ack_d   = 1'b1;
                    end
                end
                OFF_OSC: begin
                    state_d = SLEEP;
                    ack_d   = 1'b1;
                end
                SLEEP: begin
                    state_d = SLEEP;
                end
                WAKE_OSC: begin
                    tick_cnt_d = tick_sat;
                    cyc_cnt_d  = cyc_cnt_q + CYC_W'(1);
                    // Tick completion wins over a coincident timeout
                    if (tick_sat >= TICK_TARGET) begin
                        state_d = WAKE_SMCLK;
                        scg1_d  = 1'b0;
                    end else if (cyc_cnt_q == CYC_LAST) begin
                        state_d = WAKE_SMCLK;
                        scg1_d  = 1'b0;
                        fault_d = 1'b1;
                    end
                end
                WAKE_SMCLK: begin
                    state_d  = WAKE_CPU;
                    cpu_en_d = 1'b1;
                end
                WAKE_CPU: begin
                    state_d = ACTIVE;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = ACTIVE;
                end
            endcase
        end
    end

    assign cpu_en    = cpu_en_q;
    assign scg1      = scg1_q;
    assign oscoff    = oscoff_q;
    assign lpm_ack   = ack_q;
    assign lpm_rej   = rej_q;
    assign wake_done = done_q;
    assign osc_fault = fault_q;
    assign state     = state_q;

endmodule

// File: tb/tb_omsp_lpm_sequencer.sv
// Self-checking bench for omsp_lpm_sequencer: a shutdown-depth model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_omsp_lpm_sequencer;

    localparam int OSC_TICKS    = 4;
    localparam int WAKE_TIMEOUT = 1024;

    logic       mclk, por_reset_a;
    logic       lpm_req, wakeup, dbg_en_s, osc_tick, fault_clr;
    logic [1:0] lpm_mode;
    logic       cpu_en, scg1, oscoff, lpm_ack, lpm_rej, wake_done, osc_fault;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 0;

    omsp_lpm_sequencer #(.OSC_TICKS(OSC_TICKS), .WAKE_TIMEOUT(WAKE_TIMEOUT)) dut (
        .mclk(mclk), .por_reset_a(por_reset_a), .lpm_req(lpm_req), .lpm_mode(lpm_mode),
        .wakeup(wakeup), .dbg_en_s(dbg_en_s), .osc_tick(osc_tick), .fault_clr(fault_clr),
        .cpu_en(cpu_en), .scg1(scg1), .oscoff(oscoff), .lpm_ack(lpm_ack), .lpm_rej(lpm_rej),
        .wake_done(wake_done), .osc_fault(osc_fault), .state(state)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: level = number of resources switched off (CPU, SMCLK, LFXT), plus a phase
    localparam int P_IDLE = 0, P_DESC = 1, P_ASLEEP = 2, P_ASC = 3;
    int m_level, m_phase, m_mode, m_ticks, m_elapsed;
    bit m_ack, m_rej, m_done, m_fault;

    always @(posedge mclk or posedge por_reset_a) begin
        if (por_reset_a) begin
            m_level = 0; m_phase = P_IDLE; m_mode = 0; m_ticks = 0; m_elapsed = 0;
            m_ack = 0; m_rej = 0; m_done = 0; m_fault = 0;
        end else begin
            bit fault_set;
            int max_depth;
            fault_set = 0;
            m_ack = 0; m_rej = 0; m_done = 0;
            max_depth = (m_mode == 0) ? 1 : ((m_mode == 1 || dbg_en_s) ? 2 : 3);
            case (m_phase)
                P_IDLE: if (lpm_req) begin
                    if (wakeup) m_rej = 1;
                    else begin
                        m_mode  = (lpm_mode == 2'd3) ? 2 : int'(lpm_mode);
                        m_level = 1;
                        m_phase = P_DESC;
                    end
                end
                P_DESC, P_ASLEEP: if (wakeup) begin
                    if (m_level == 3) begin m_ticks = 0; m_elapsed = 0; end
                    m_level--;
                    m_phase = P_ASC;
                end else if (m_phase == P_DESC) begin
                    if (m_level < max_depth) m_level++;
                    else begin m_phase = P_ASLEEP; m_ack = 1; end
                end
                default: begin
                    if (m_level == 2) begin
                        if (osc_tick && m_ticks < 15) m_ticks++;
                        if (m_ticks >= OSC_TICKS) m_level = 1;
                        else if (m_elapsed == WAKE_TIMEOUT - 1) begin m_level = 1; fault_set = 1; end
                        else m_elapsed++;
                    end else if (m_level == 1) m_level = 0;
                    else begin m_phase = P_IDLE; m_done = 1; end
                end
            endcase
            if (fault_set) m_fault = 1;
            else if (fault_clr) m_fault = 0;
        end
    end

    function automatic logic [9:0] model_vec();
        logic [2:0] st;
        case (m_phase)
            P_IDLE:   st = 3'd0;
            P_DESC:   st = 3'(m_level);
            P_ASLEEP: st = 3'd4;
            default:  st = 3'(7 - m_level);
        endcase
        return {st, m_level == 0, m_level >= 2, m_level >= 3, m_ack, m_rej, m_done, m_fault};
    endfunction

    // Every-cycle comparison against the model
    always @(negedge mclk) begin
        if (cmp_en && !por_reset_a)
            check("cycle", 16'({state, cpu_en, scg1, oscoff, lpm_ack, lpm_rej, wake_done, osc_fault}),
                  16'(model_vec()));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic request(input logic [1:0] mode);
        @(negedge mclk); lpm_mode = mode; lpm_req = 1'b1;
        @(negedge mclk); lpm_req = 1'b0;
    endtask

    task automatic wait_state(input string name, input logic [2:0] s, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (state == s) break;
            @(negedge mclk);
        end
        check(name, 16'(state), 16'(s));
    endtask

    // Sits in WAKE_OSC counting dwell cycles; optional ticks incl. one on the last cycle
    task automatic run_wake_osc(input bit with_ticks, output int dwell);
        dwell = 0;
        for (int j = 0; j < 1100; j++) begin
            if (state != 3'd5) break;
            dwell++;
            osc_tick = with_ticks && (j == 100 || j == 200 || j == 300 || j == WAKE_TIMEOUT - 1);
            @(negedge mclk);
            osc_tick = 1'b0;
        end
    endtask

    task automatic sleep_mode2_and_wake();
        request(2'd2);
        wait_state("reach_sleep", 3'd4, 8);
        @(negedge mclk); wakeup = 1'b1;
        @(negedge mclk); wakeup = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dwell;
        por_reset_a = 1'b1; lpm_req = 0; lpm_mode = 0; wakeup = 0;
        dbg_en_s = 0; osc_tick = 0; fault_clr = 0;
        cyc(3);
        check("rst_vec", 16'({state, cpu_en, scg1, oscoff, lpm_ack, lpm_rej, wake_done, osc_fault}),
              16'(10'b000_1000000));
        #2 por_reset_a = 1'b0;
        cmp_en = 1;
        cyc(2);

        // Mode-2 entry
        request(2'd2);
        check("e2_s1", 16'(state), 16'd1); check("e2_cpu", 16'(cpu_en), 16'd0);
        @(negedge mclk); check("e2_s2", 16'(state), 16'd2); check("e2_scg1", 16'(scg1), 16'd1);
        @(negedge mclk); check("e2_s3", 16'(state), 16'd3); check("e2_oscoff", 16'(oscoff), 16'd1);
        check("e2_noack", 16'(lpm_ack), 16'd0);
        @(negedge mclk); check("e2_s4", 16'(state), 16'd4); check("e2_ack", 16'(lpm_ack), 16'd1);
        @(negedge mclk); check("e2_ack_once", 16'(lpm_ack), 16'd0);
        osc_tick = 1'b1;
        @(negedge mclk); osc_tick = 1'b0;

        // Wake with four ticks 10 cycles apart
        wakeup = 1'b1;
        @(negedge mclk); wakeup = 1'b0;
        check("w2_s5", 16'(state), 16'd5); check("w2_oscoff", 16'(oscoff), 16'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(9); osc_tick = 1'b1;
            @(negedge mclk); osc_tick = 1'b0;
        end
        check("w2_s6", 16'(state), 16'd6); check("w2_scg1", 16'(scg1), 16'd0);
        @(negedge mclk); check("w2_s7", 16'(state), 16'd7); check("w2_cpu", 16'(cpu_en), 16'd1);
        @(negedge mclk); check("w2_done", 16'(wake_done), 16'd1); check("w2_fault", 16'(osc_fault), 16'd0);
        cyc(2);

        // Timeout without ticks, entered via mode 3
        request(2'd3);
        wait_state("to_sleep", 3'd4, 8);
        @(negedge mclk); wakeup = 1'b1;
        @(negedge mclk); wakeup = 1'b0;
        run_wake_osc(1'b0, dwell);
        check("to_dwell", 16'(dwell), 16'd1024);
        check("to_fault", 16'(osc_fault), 16'd1);
        cyc(4);
        check("to_fault_sticky", 16'(osc_fault), 16'd1);
        fault_clr = 1'b1;
        @(negedge mclk); fault_clr = 1'b0;
        check("to_fault_clr", 16'(osc_fault), 16'd0);
        cyc(2);

        // Last tick coincident with timeout: no fault
        sleep_mode2_and_wake();
        run_wake_osc(1'b1, dwell);
        check("tt_dwell", 16'(dwell), 16'd1024);
        check("tt_nofault", 16'(osc_fault), 16'd0);
        cyc(4);

        // Reject while wakeup pending
        @(negedge mclk); wakeup = 1'b1; lpm_mode = 2'd2; lpm_req = 1'b1;
        @(negedge mclk); lpm_req = 1'b0; wakeup = 1'b0;
        check("rej_pulse", 16'(lpm_rej), 16'd1); check("rej_state", 16'(state), 16'd0);
        check("rej_cpu", 16'(cpu_en), 16'd1);
        @(negedge mclk); check("rej_once", 16'(lpm_rej), 16'd0);

        // Mode 2 with debug active: LFXT kept running
        dbg_en_s = 1'b1;
        request(2'd2);
        @(negedge mclk); check("dbg_s2", 16'(state), 16'd2);
        @(negedge mclk); check("dbg_s4", 16'(state), 16'd4); check("dbg_ack", 16'(lpm_ack), 16'd1);
        check("dbg_oscoff", 16'(oscoff), 16'd0);
        @(negedge mclk); wakeup = 1'b1;
        @(negedge mclk); wakeup = 1'b0; check("dbg_w6", 16'(state), 16'd6);
        cyc(2); check("dbg_done", 16'(wake_done), 16'd1);
        dbg_en_s = 1'b0;

        // Mode 0, with a stray request during SLEEP
        request(2'd0);
        @(negedge mclk); check("m0_sleep", 16'(state), 16'd4); check("m0_ack", 16'(lpm_ack), 16'd1);
        lpm_req = 1'b1;
        @(negedge mclk); lpm_req = 1'b0;
        @(negedge mclk); check("m0_ignore", 16'(state), 16'd4); check("m0_norej", 16'(lpm_rej), 16'd0);
        wakeup = 1'b1;
        @(negedge mclk); wakeup = 1'b0; check("m0_w7", 16'(state), 16'd7); check("m0_cpu", 16'(cpu_en), 16'd1);
        @(negedge mclk); check("m0_done", 16'(wake_done), 16'd1);

        // Wake-up during OFF_SMCLK aborts entry
        request(2'd2);
        @(negedge mclk); check("ab_s2", 16'(state), 16'd2); wakeup = 1'b1;
        @(negedge mclk); wakeup = 1'b0;
        check("ab_s6", 16'(state), 16'd6); check("ab_noack", 16'(lpm_ack), 16'd0);
        cyc(3);

        // Asynchronous reset in WAKE_OSC
        sleep_mode2_and_wake();
        cyc(3);
        check("rs_in5", 16'(state), 16'd5);
        #2 por_reset_a = 1'b1;
        #1 check("rs_vec", 16'({state, cpu_en, scg1, oscoff, lpm_ack, lpm_rej, wake_done, osc_fault}),
                 16'(10'b000_1000000));
        @(negedge mclk); #2 por_reset_a = 1'b0;
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
